// File: rtl/riscv_dm_ctrl.sv
// Data-memory responder for the RV64IMC load/store port: one-cycle loads,
// single-cycle doubleword stores, two-cycle read-modify-write for narrower stores.
module riscv_dm_ctrl #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic        i_riscv_dmc_clk,
  input  logic        i_riscv_dmc_rst,
  input  logic        i_riscv_dmc_req,
  input  logic        i_riscv_dmc_wen,
  input  logic [1:0]  i_riscv_dmc_sel,
  input  logic [63:0] i_riscv_dmc_addr,
  input  logic [63:0] i_riscv_dmc_wdata,
  output logic [63:0] o_riscv_dmc_rdata,
  output logic        o_riscv_dmc_rvalid,
  output logic        o_riscv_dmc_stall,
  output logic        o_riscv_dmc_misalign
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned OFF_W = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } state_e;

  state_e state;

  logic [XLEN-1:0] mem [DEPTH];

  logic             accept;
  logic             req_misalign;
  logic             load_go;
  logic             dw_store;
  logic             rmw_start;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [XLEN-1:0]  rd_word;
  logic [XLEN-1:0]  load_data;

  logic [IDX_W-1:0] rmw_idx;
  logic [OFF_W-1:0] rmw_off;
  logic [1:0]       rmw_sel;
  logic [XLEN-1:0]  rmw_old;
  logic [XLEN-1:0]  rmw_wdata;
  logic [XLEN-1:0]  rmw_mask;
  logic [XLEN-1:0]  rmw_merged;

  // Upper address bits are deliberately ignored: the array wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_riscv_dmc_addr[XLEN-1:IDX_W+3];

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sel);
    case (sel)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  assign o_riscv_dmc_stall = (state == S_RMW);
  assign accept            = i_riscv_dmc_req & ~o_riscv_dmc_stall;
  assign req_idx           = i_riscv_dmc_addr[IDX_W+2:3];
  assign req_off           = i_riscv_dmc_addr[2:0];

  always_comb begin
    req_misalign = 1'b0;
    case (i_riscv_dmc_sel)
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = i_riscv_dmc_addr[0];
      2'b10:   req_misalign = |i_riscv_dmc_addr[1:0];
      default: req_misalign = |i_riscv_dmc_addr[2:0];
    endcase
  end

  assign load_go   = accept & ~req_misalign & ~i_riscv_dmc_wen;
  assign dw_store  = accept & ~req_misalign & i_riscv_dmc_wen & (i_riscv_dmc_sel == 2'b11);
  assign rmw_start = accept & ~req_misalign & i_riscv_dmc_wen & (i_riscv_dmc_sel != 2'b11);

  // Combinational array read sees writes from the previous edge.
  assign rd_word   = mem[req_idx];
  assign load_data = (rd_word >> {req_off, 3'b000}) & size_mask(i_riscv_dmc_sel);

  assign rmw_mask   = size_mask(rmw_sel) << {rmw_off, 3'b000};
  assign rmw_merged = (rmw_old & ~rmw_mask) | ((rmw_wdata << {rmw_off, 3'b000}) & rmw_mask);

  // Control state and registered response outputs.
  always_ff @(posedge i_riscv_dmc_clk) begin
    if (i_riscv_dmc_rst) begin
      state                <= S_IDLE;
      o_riscv_dmc_rdata    <= '0;
      o_riscv_dmc_rvalid   <= 1'b0;
      o_riscv_dmc_misalign <= 1'b0;
    end else begin
      o_riscv_dmc_rvalid   <= load_go;
      o_riscv_dmc_misalign <= accept & req_misalign;
      if (load_go) begin
        o_riscv_dmc_rdata <= load_data;
      end
      case (state)
        S_IDLE: if (rmw_start) state <= S_RMW;
        S_RMW:  state <= S_IDLE;
      endcase
    end
  end

  // Operands captured for the merge cycle.
  always_ff @(posedge i_riscv_dmc_clk) begin
    if (rmw_start) begin
      rmw_idx   <= req_idx;
      rmw_off   <= req_off;
      rmw_sel   <= i_riscv_dmc_sel;
      rmw_old   <= rd_word;
      rmw_wdata <= i_riscv_dmc_wdata;
    end
  end

  // Array write port; a reset during the merge cycle drops the pending write.
  always_ff @(posedge i_riscv_dmc_clk) begin
    if (!i_riscv_dmc_rst) begin
      if (state == S_RMW) begin
        mem[rmw_idx] <= rmw_merged;
      end else if (dw_store) begin
        mem[req_idx] <= i_riscv_dmc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dm_ctrl.sv
// Bench for riscv_dm_ctrl: byte-addressed reference memory, directed scenarios,
// then randomized traffic with stall-hold behaviour.
module tb_riscv_dm_ctrl;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned NBYTES = 8 * DEPTH;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        wen   = 1'b0;
  logic [1:0]  sel   = 2'b00;
  logic [63:0] addr  = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        rvalid;
  logic        stall;
  logic        misalign;

  riscv_dm_ctrl #(.DEPTH(DEPTH)) dut (
    .i_riscv_dmc_clk     (clk),
    .i_riscv_dmc_rst     (rst),
    .i_riscv_dmc_req     (req),
    .i_riscv_dmc_wen     (wen),
    .i_riscv_dmc_sel     (sel),
    .i_riscv_dmc_addr    (addr),
    .i_riscv_dmc_wdata   (wdata),
    .o_riscv_dmc_rdata   (rdata),
    .o_riscv_dmc_rvalid  (rvalid),
    .o_riscv_dmc_stall   (stall),
    .o_riscv_dmc_misalign(misalign)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: flat byte memory plus one pending narrow store.
  logic [7:0]  mbytes [NBYTES];
  bit          pend = 1'b0;
  int unsigned pend_base;
  int unsigned pend_n;
  logic [63:0] pend_data;
  logic [63:0] exp_rdata = '0;
  bit          exp_rv;
  bit          exp_mis;

  function automatic int unsigned wrap(input logic [63:0] a);
    return 32'(a % 64'(NBYTES));
  endfunction

  task automatic write_bytes(input int unsigned base, input int unsigned n, input logic [63:0] d);
    for (int unsigned i = 0; i < n; i++) mbytes[(base + i) % NBYTES] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] read_bytes(input int unsigned base, input int unsigned n);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = mbytes[(base + i) % NBYTES];
    return v;
  endfunction

  task automatic check1(input string tag, input logic got, input logic exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    vectors++;
    check1("rvalid", rvalid, exp_rv);
    check1("misalign", misalign, exp_mis);
    check1("stall", stall, pend);
    check64("rdata", rdata, exp_rdata);
  endtask

  // One clock with the given request; reports whether the request was taken.
  task automatic step(input bit r, input bit w, input logic [1:0] s,
                      input logic [63:0] a, input logic [63:0] d, output bit taken);
    int unsigned n;
    bit acc;
    bit mis;
    n     = 32'd1 << s;
    acc   = r && !pend;
    taken = acc || !r;
    mis   = (a % 64'(n)) != 64'd0;
    req = r; wen = w; sel = s; addr = a; wdata = d;
    exp_rv  = 1'b0;
    exp_mis = 1'b0;
    if (pend) begin
      write_bytes(pend_base, pend_n, pend_data);
      pend = 1'b0;
    end
    if (acc) begin
      if (mis) exp_mis = 1'b1;
      else if (w) begin
        if (n == 8) write_bytes(wrap(a), 8, d);
        else begin
          pend      = 1'b1;
          pend_base = wrap(a);
          pend_n    = n;
          pend_data = d;
        end
      end else begin
        exp_rdata = read_bytes(wrap(a), n);
        exp_rv    = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  // Present a request, holding it while the responder stalls.
  task automatic issue(input bit r, input bit w, input logic [1:0] s,
                       input logic [63:0] a, input logic [63:0] d);
    bit t;
    t = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(r, w, s, a, d, t);
      if (t) break;
    end
    assert (t) else begin
      miscompares++;
      $error("FAIL issue: request at %h never accepted", a);
    end
  endtask

  task automatic idle();
    bit t;
    step(1'b0, 1'b0, 2'b00, '0, '0, t);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 1'b0;
    pend      = 1'b0;
    exp_rdata = '0;
    exp_rv    = 1'b0;
    exp_mis   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    bit w;
    logic [1:0]  s;
    logic [63:0] a;
    logic [63:0] d;

    @(posedge clk); #1;
    do_reset();

    // Fill the whole array so every later load has a known value.
    for (int unsigned i = 0; i < DEPTH; i++) issue(1'b1, 1'b1, 2'b11, 64'(i) * 64'd8, {$urandom, $urandom});

    issue(1'b1, 1'b1, 2'b11, 64'h0, 64'h1122334455667788);
    issue(1'b1, 1'b0, 2'b11, 64'h0, '0);
    check64("plan_dw_load", rdata, 64'h1122334455667788);

    issue(1'b1, 1'b1, 2'b00, 64'h5, 64'hAB);
    check1("plan_byte_stall", stall, 1'b1);
    issue(1'b1, 1'b0, 2'b11, 64'h0, '0);
    check64("plan_byte_merge", rdata, 64'h1122AB4455667788);

    issue(1'b1, 1'b1, 2'b01, 64'h2, 64'hBEEF);
    issue(1'b1, 1'b0, 2'b10, 64'h0, '0);
    check64("plan_word_zext", rdata, 64'h00000000BEEF7788);

    issue(1'b1, 1'b1, 2'b10, 64'h6, 64'hDEADBEEF);
    check1("plan_misalign", misalign, 1'b1);
    issue(1'b1, 1'b0, 2'b11, 64'h0, '0);
    check64("plan_misalign_nowrite", rdata, 64'h1122AB44BEEF7788);

    issue(1'b1, 1'b1, 2'b11, 64'h1000, 64'hCAFEF00D12345678);
    issue(1'b1, 1'b0, 2'b11, 64'h0, '0);
    check64("plan_wrap", rdata, 64'hCAFEF00D12345678);
    issue(1'b1, 1'b0, 2'b11, 64'h8, '0);
    check1("plan_b2b_rvalid", rvalid, 1'b1);

    issue(1'b1, 1'b1, 2'b11, 64'h10, 64'h0123456789ABCDEF);
    issue(1'b1, 1'b1, 2'b00, 64'h10, 64'h5A);
    do_reset();
    issue(1'b1, 1'b0, 2'b11, 64'h10, '0);
    check64("plan_rst_abandon", rdata, 64'h0123456789ABCDEF);

    for (int it = 0; it < 600; it++) begin
      r = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 1) != 0);
      s = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << s) - 64'd1);
      d = {$urandom, $urandom};
      issue(r, w, s, a, d);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
